// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared types and constants for the fetch PC sequencer: PC geometry,
// EXE correction encodings and the per-stage PC/prediction record.
package fetch_pc_sequencer_pkg;

  localparam int unsigned      PC_W     = 10;
  localparam logic [PC_W-1:0]  RESET_PC = 10'h000;

  localparam logic [1:0] CORR_NONE = 2'b00;
  localparam logic [1:0] CORR_CNI  = 2'b10;
  localparam logic [1:0] CORR_PBT  = 2'b11;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            pred;
    logic            valid;
  } pipe_pc_t;

  // Sequential successor of a fetch PC; wraps naturally at 2^PC_W.
  function automatic logic [PC_W-1:0] seq_pc(input logic [PC_W-1:0] pc);
    return pc + {{(PC_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/fetch_pc_sequencer_sat_counter.sv
// Saturating event counter: increments by one on each enabled edge and
// sticks at all-ones. Output is registered, no backpressure.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             nrst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Program counter plus IF->ID->EXE PC/prediction pipeline around the branch
// predictor; EXE corrections redirect fetch next cycle and squash IF/ID, ID/EXE.
module fetch_pc_sequencer #(
  parameter int unsigned                     PC_W     = fetch_pc_sequencer_pkg::PC_W,
  parameter logic [fetch_pc_sequencer_pkg::PC_W-1:0] RESET_PC = fetch_pc_sequencer_pkg::RESET_PC,
  parameter int unsigned                     CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             nrst,
  input  logic             stall,
  input  logic             if_prediction,
  input  logic [PC_W-1:0]  if_PBT,
  input  logic [1:0]       exe_correction,
  input  logic [PC_W-1:0]  exe_CNI,
  input  logic [PC_W-1:0]  exe_PBT,
  output logic [PC_W-1:0]  if_PC,
  output logic [PC_W-1:0]  id_PC,
  output logic             id_valid,
  output logic             id_pred,
  output logic [PC_W-1:0]  exe_PC,
  output logic             exe_valid,
  output logic             exe_pred,
  output logic             flush,
  output logic [CNT_W-1:0] mispredict_cnt,
  output logic [CNT_W-1:0] taken_redirect_cnt
);

  import fetch_pc_sequencer_pkg::*;

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  pipe_pc_t        id_q;
  pipe_pc_t        id_d;
  pipe_pc_t        exe_q;
  pipe_pc_t        exe_d;

  logic redirect;
  logic taken_inc;

  // Bubbles in EXE never redirect, whatever the predictor drives.
  assign redirect  = exe_q.valid & exe_correction[1];
  assign taken_inc = ~redirect & ~stall & if_prediction;

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = (exe_correction == CORR_PBT) ? exe_PBT : exe_CNI;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (if_prediction) begin
      pc_d = if_PBT;
    end else begin
      pc_d = seq_pc(pc_q);
    end
  end

  always_comb begin
    id_d = id_q;
    if (redirect) begin
      id_d.valid = 1'b0;
      id_d.pred  = 1'b0;
    end else if (!stall) begin
      id_d.pc    = pc_q;
      id_d.pred  = if_prediction;
      id_d.valid = 1'b1;
    end
  end

  // A stall leaves ID in place, so EXE receives a bubble rather than a copy.
  always_comb begin
    exe_d = exe_q;
    if (redirect) begin
      exe_d.valid = 1'b0;
      exe_d.pred  = 1'b0;
    end else if (stall) begin
      exe_d.valid = 1'b0;
    end else begin
      exe_d = id_q;
    end
  end

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      pc_q  <= RESET_PC;
      id_q  <= '0;
      exe_q <= '0;
    end else begin
      pc_q  <= pc_d;
      id_q  <= id_d;
      exe_q <= exe_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_mispredict_cnt (
    .clk_i  (CLK),
    .nrst_i (nrst),
    .inc_i  (redirect),
    .cnt_o  (mispredict_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_taken_cnt (
    .clk_i  (CLK),
    .nrst_i (nrst),
    .inc_i  (taken_inc),
    .cnt_o  (taken_redirect_cnt)
  );

  assign if_PC     = pc_q;
  assign id_PC     = id_q.pc;
  assign id_valid  = id_q.valid;
  assign id_pred   = id_q.pred;
  assign exe_PC    = exe_q.pc;
  assign exe_valid = exe_q.valid;
  assign exe_pred  = exe_q.pred;
  assign flush     = redirect;

endmodule

// File: doc/fetch_pc_sequencer.md
Name: fetch_pc_sequencer

Overview:
- Owns the program counter and the IF->ID->EXE PC/prediction pipeline registers around the branch predictor.
- Each cycle it picks the next fetch PC from the IF-stage prediction or the EXE-stage correction.
- It drives if_PC, id_PC and exe_PC back into the predictor, and generates the pipeline flush and the mispredict statistics.

Parameters:
- PC_W, 10, PC width in instruction-word index units.
- RESET_PC, 10'h000, PC value loaded on reset.
- CNT_W, 16, width of the saturating mispredict and redirect counters.

Ports:
- CLK  in  1  clock, rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- stall  in  1  hazard stall from the decode/hazard unit; freezes PC and the IF/ID register.
- if_prediction  in  1  predictor's taken bit for the current if_PC.
- if_PBT  in  PC_W  predicted branch target for the current if_PC.
- exe_correction  in  2  predictor correction: 0x = none, 10 = go to exe_CNI, 11 = go to exe_PBT.
- exe_CNI  in  PC_W  correct next instruction after a wrongly-taken prediction.
- exe_PBT  in  PC_W  branch target after a wrongly-not-taken prediction.
- if_PC  out  PC_W  current fetch PC.
- id_PC  out  PC_W  PC held in the IF/ID register.
- id_valid  out  1  IF/ID register holds a live instruction.
- id_pred  out  1  prediction taken at fetch for the IF/ID instruction.
- exe_PC  out  PC_W  PC held in the ID/EXE register.
- exe_valid  out  1  ID/EXE register holds a live instruction.
- exe_pred  out  1  prediction carried to EXE.
- flush  out  1  combinational; kill the IF/ID and ID/EXE contents this cycle.
- mispredict_cnt  out  CNT_W  saturating count of accepted corrections.
- taken_redirect_cnt  out  CNT_W  saturating count of predicted-taken redirects from IF.

Behaviour:
- Reset (nrst=0, async):
  - if_PC = RESET_PC.
  - id_PC, exe_PC = 0; id_valid, exe_valid, id_pred, exe_pred = 0.
  - Both counters = 0.
  - Reset releases on the next CLK edge after nrst rises; reset mid-operation discards all in-flight state.
- redirect = exe_valid & exe_correction[1]. flush = redirect, purely combinational, same cycle.
- Next-PC priority, highest first:
  1. redirect & exe_correction[0]=0 -> exe_CNI.
  2. redirect & exe_correction[0]=1 -> exe_PBT.
  3. stall -> hold if_PC.
  4. if_prediction -> if_PBT.
  5. otherwise if_PC+1, modulo 2^PC_W (all-ones wraps to 0).
- IF/ID register on each edge:
  - redirect: id_valid=0, id_pred=0, id_PC unchanged.
  - else stall: hold all fields.
  - else: id_PC=if_PC, id_pred=if_prediction, id_valid=1.
- ID/EXE register on each edge:
  - redirect: exe_valid=0, exe_pred=0.
  - else stall: bubble, i.e. exe_valid=0 with exe_PC unchanged.
  - else: exe_PC=id_PC, exe_pred=id_pred, exe_valid=id_valid.
- Simultaneous stall and redirect: redirect wins; stall is ignored that cycle.
- exe_correction is ignored when exe_valid=0, so bubbles never redirect.
- Latency:
  - Correction seen in EXE in cycle N -> new if_PC visible in cycle N+1.
  - The two younger stages are squashed, giving a 2-cycle penalty.
- mispredict_cnt: +1 on every redirect edge; saturates at all-ones.
- taken_redirect_cnt: +1 on an edge with !redirect & !stall & if_prediction; saturates.
- Timing: all outputs except flush are registered. Allowed combinational paths:
  - if_prediction/if_PBT -> next PC.
  - exe_correction -> flush.

Decomposition:
- Shared package holds:
  - PC_W and RESET_PC.
  - The correction encodings CORR_NONE=2'b00, CORR_CNI=2'b10, CORR_PBT=2'b11.
  - A pipe_pc_t struct {pc, pred, valid}.
- One sub-module: sat_counter (CNT_W, inc enable, async nrst). Instantiate it twice.

Test Plan:
- Reset: hold nrst=0 for 3 cycles, then release -> if_PC=0x000, id_valid=0, exe_valid=0, counters 0. Then no prediction for 4 cycles -> if_PC steps 0x001, 0x002, 0x003, 0x004.
- Predicted taken: if_PC=0x010 with if_prediction=1, if_PBT=0x080 -> next if_PC=0x080; id_PC=0x010, id_pred=1; taken_redirect_cnt=1.
- Wrongly taken: while exe_valid=1, drive exe_correction=10 with exe_CNI=0x015 -> flush=1 that cycle; next if_PC=0x015; id_valid=0, exe_valid=0; mispredict_cnt=1.
- Redirect beats stall: stall=1 together with exe_correction=11 and exe_PBT=0x200 -> if_PC=0x200 next cycle; both stages invalid.
- Stall and bubble: hold stall=1 for 2 cycles at if_PC=0x030 -> if_PC and id_PC hold; exe_valid=0 both cycles; exe_correction=11 is ignored while exe_valid=0 (flush=0).
- Wrap and saturation: if_PC=0x3FF with no prediction -> 0x000. Force mispredict_cnt to 0xFFFF then apply a redirect -> it stays 0xFFFF.
